axon_output_drain: RTL and testbench
====================================

Name: axon_output_drain

Overview:
- Tail-end collector for a chain of AXON PEs. It generates the shared output-eject control for the chain and captures the psums as they shift out of the last PE.
- Captured psums are buffered and written to output SRAM over a valid/ready write port, with addresses in PE order.
- One instance per PE chain (row), placed between the chain tail's output_out and the output SRAM write port.

Parameters:
- DATA_WIDTH, 16, width of psum / chain data
- NUM_PE, 8, PEs in the chain; also the capture count and the FIFO depth (must be >= 2)
- ADDR_WIDTH, 10, SRAM word address width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a drain; ignored while busy=1
- base_addr  in  ADDR_WIDTH  SRAM address of PE index 0; sampled when start is accepted
- chain_in  in  DATA_WIDTH  output_out of the tail PE (index NUM_PE-1)
- eject_ctrl  out  1  drives output_eject_ctrl of every PE in the chain
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last SRAM write is accepted
- wr_valid  out  1  SRAM write request
- wr_ready  in  1  SRAM accepts the write when wr_valid & wr_ready
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data

Behaviour:
- Reset: eject_ctrl=0, busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0. FIFO empty, counters 0, state IDLE.
- Reset asserted mid-drain aborts the drain: the FIFO is discarded and no done pulse is issued.
- Chain protocol, as fixed by the PE:
  - When eject_ctrl=1 at an edge, every PE loads output_reg <= psum_reg.
  - When eject_ctrl=0, the chain shifts by one each cycle, with no stall.
  - Hence, after the eject edge, chain_in presents psum[NUM_PE-1], psum[NUM_PE-2], ..., psum[0] on consecutive cycles.
- FSM states:
  - IDLE: on start=1, latch base_addr, clear counters, go to EJECT.
  - EJECT: exactly one cycle; eject_ctrl=1. Go to SHIFT.
  - SHIFT: lasts NUM_PE cycles; eject_ctrl=0. In SHIFT cycle k (k=0..NUM_PE-1), push {chain_in, addr=base_addr+NUM_PE-1-k} into the FIFO at the clock edge. After the NUM_PE-th push, go to FLUSH.
  - FLUSH: stay while the FIFO is non-empty or a write is pending.
  - DONE: the cycle after the last accepted write; done=1 for one cycle, busy=0 from the next cycle, then return to IDLE.
  - FLUSH->DONE may occur in the cycle after SHIFT ends if all writes have already completed.
- eject_ctrl is high only in EJECT. It is never re-asserted before SHIFT completes, so in-flight chain data cannot be overwritten.
- busy is 1 in EJECT, SHIFT, FLUSH and DONE. A start during busy is dropped; no queuing.
- FIFO:
  - Depth NUM_PE, first-in first-out. Entry is {data, addr}.
  - Captures are unconditional; depth NUM_PE guarantees no overflow, even with wr_ready=0 for the whole drain.
  - A push and a pop in the same cycle are both performed.
- Write port:
  - wr_valid = FIFO non-empty. wr_addr and wr_data come from the FIFO head.
  - While wr_valid & !wr_ready, wr_addr and wr_data are held stable.
  - Writes can begin in the cycle after the first capture and may overlap SHIFT.
  - The first word written is to base_addr+NUM_PE-1 and the last to base_addr.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Latency with wr_ready tied to 1: start at cycle 0 -> eject_ctrl at cycle 1 -> first wr_valid at cycle 3 -> last write at cycle NUM_PE+2 -> done at cycle NUM_PE+3.

Optional Feature:
- Macro: AXON_DRAIN_RELU_EN.
- When defined: each captured word is passed through ReLU before the FIFO push. If the MSB is 1 (negative in two's complement), 0 is stored; otherwise the word is stored unchanged.
- When undefined: words are stored unmodified.
- Timing, addresses and handshake are identical in both builds.

Test Plan:
- Basic drain: NUM_PE=4, chain_in model pre-loaded with psums {0x0011, 0x0022, 0x0033, 0x0044} (PE0..PE3), base_addr=0x100, wr_ready=1, start at cycle 0 -> eject_ctrl=1 only in cycle 1; writes in order (0x103,0x0044), (0x102,0x0033), (0x101,0x0022), (0x100,0x0011); done pulses once at cycle 7.
- Backpressure: same data, wr_ready=0 until cycle 12 -> exactly 4 FIFO entries with no loss; wr_addr/wr_data stable while stalled; same write order; done one cycle after the 4th accepted write.
- Random wr_ready (50%) over 20 drains with random base_addr -> every SRAM word matches the model, and each drain gives exactly one done and one eject pulse.
- Start while busy: start re-pulsed in cycle 3 -> ignored; a single eject pulse and a single done.
- Reset mid-drain: rst=1 in cycle 4 with wr_ready=0 -> next cycle all outputs 0 and busy=0, no done; a fresh start then completes normally.
- Wrap-around and ReLU: base_addr=0x3FE, NUM_PE=4 -> addresses 0x001, 0x000, 0x3FF, 0x3FE. With AXON_DRAIN_RELU_EN, psum 0x8005 is written as 0x0000 and 0x7FFF unchanged.

Source files
------------

// File: rtl/axon_output_drain.sv
// Tail collector for an AXON PE chain: pulses the chain eject, captures NUM_PE psums
// into a FIFO and writes them to output SRAM in PE order. Define AXON_DRAIN_RELU_EN to ReLU captures.
module axon_output_drain #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DATA_WIDTH-1:0] chain_in,
   output logic                  eject_ctrl,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data
);

   localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int CNT_W = $clog2(NUM_PE + 1);
   localparam logic [PTR_W-1:0]      LAST_IDX = PTR_W'(NUM_PE - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_OFS = ADDR_WIDTH'(NUM_PE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EJECT,
      S_SHIFT,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [PTR_W-1:0]        shift_cnt_q, shift_cnt_d;
   logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;

   logic [DATA_WIDTH-1:0]   data_mem [NUM_PE];
   logic [ADDR_WIDTH-1:0]   addr_mem [NUM_PE];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    push, pop;

   function automatic logic [DATA_WIDTH-1:0] capture_word(input logic signed [DATA_WIDTH-1:0] d);
`ifdef AXON_DRAIN_RELU_EN
      if (d < 0) return '0;
      return d;
`else
      return d;
`endif
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
   endfunction

   // Control state: FSM, shift counter and the descending capture address
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_cnt_q <= '0;
         cap_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         cap_addr_q  <= cap_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      cap_addr_d  = cap_addr_q;
      eject_ctrl  = 1'b0;
      done        = 1'b0;
      push        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Tail PE's word arrives first, so capture starts at the highest address
               cap_addr_d  = base_addr + LAST_OFS;
               shift_cnt_d = '0;
               state_d     = S_EJECT;
            end
         end
         S_EJECT: begin
            eject_ctrl = 1'b1;
            state_d    = S_SHIFT;
         end
         S_SHIFT: begin
            push        = 1'b1;
            shift_cnt_d = shift_cnt_q + PTR_W'(1);
            cap_addr_d  = cap_addr_q - ADDR_WIDTH'(1);
            if (shift_cnt_q == LAST_IDX) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (count_q == '0 || (count_q == CNT_W'(1) && pop)) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);

   // FIFO bookkeeping; storage itself carries no reset
   assign wr_valid = (count_q != '0);
   assign pop      = wr_valid & wr_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= capture_word(chain_in);
         addr_mem[wr_ptr_q] <= cap_addr_q;
      end
   end

   // Head is only presented while valid so an empty FIFO shows zeros
   assign wr_addr = wr_valid ? addr_mem[rd_ptr_q] : '0;
   assign wr_data = wr_valid ? data_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_axon_output_drain.sv
// Directed bench for axon_output_drain (NUM_PE=4) with a behavioural PE chain and SRAM log.
module tb_axon_output_drain;

   localparam int DW = 16;
   localparam int NP = 4;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [DW-1:0] chain_in;
   logic          eject_ctrl, busy, done, wr_valid;
   logic          wr_ready = 1'b0;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   axon_output_drain #(.DATA_WIDTH(DW), .NUM_PE(NP), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .chain_in(chain_in),
      .eject_ctrl(eject_ctrl), .busy(busy), .done(done), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   // PE chain model: eject loads every output_reg, otherwise shift toward the tail
   logic [DW-1:0] pe_psum [NP];
   logic [DW-1:0] out_reg [NP];
   always @(posedge clk) begin
      if (eject_ctrl) begin
         for (int i = 0; i < NP; i++) out_reg[i] <= pe_psum[i];
      end else begin
         out_reg[0] <= '0;
         for (int i = 1; i < NP; i++) out_reg[i] <= out_reg[i-1];
      end
   end
   assign chain_in = out_reg[NP-1];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] d);
`ifdef AXON_DRAIN_RELU_EN
      return d[DW-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   // Event log filled at the falling edge
   int            cur_rel = 0;
   int            ej_cnt, ej_cyc, done_cnt, done_cyc, first_v;
   logic [AW-1:0] wa [$];
   logic [DW-1:0] wd [$];
   logic          stall_prev;
   logic [AW-1:0] prev_a;
   logic [DW-1:0] prev_d;

   task automatic clr();
      ej_cnt = 0; ej_cyc = -1; done_cnt = 0; done_cyc = -1; first_v = -1;
      wa.delete(); wd.delete(); stall_prev = 1'b0;
   endtask

   always @(negedge clk) begin
      if (eject_ctrl) begin ej_cnt++; ej_cyc = cur_rel; end
      if (done) begin done_cnt++; done_cyc = cur_rel; end
      if (wr_valid && first_v < 0) first_v = cur_rel;
      if (wr_valid && wr_ready) begin wa.push_back(wr_addr); wd.push_back(wr_data); end
      if (stall_prev && wr_valid) begin
         chk("hold_addr", 32'(wr_addr), 32'(prev_a));
         chk("hold_data", 32'(wr_data), 32'(prev_d));
      end
      stall_prev = wr_valid && !wr_ready;
      prev_a = wr_addr;
      prev_d = wr_data;
   end

   // One drain: start in relative cycle 0, optional re-start and reset, wr_ready policy
   task automatic run_drain(input logic [AW-1:0] base, input int ready_from, input bit rnd,
                            input int restart_at, input int rst_at);
      clr();
      for (int rel = 0; rel < 80; rel++) begin
         @(posedge clk); #1;
         cur_rel   = rel;
         start     = (rel == 0) || (rel == restart_at);
         base_addr = (rel == 0) ? base : ~base;
         rst       = (rel == rst_at);
         wr_ready  = rnd ? 1'($urandom_range(0, 1)) : (rel >= ready_from);
         if (rst_at >= 0 && rel == rst_at + 1) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_eject", 32'(eject_ctrl), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_wr_valid", 32'(wr_valid), 0);
            chk("rst_wr_addr", 32'(wr_addr), 0);
            chk("rst_wr_data", 32'(wr_data), 0);
         end
         if (rst_at >= 0 && rel >= rst_at + 8) break;
         if (done_cnt > 0 && rel >= done_cyc + 2) break;
      end
      start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic check_drain(input string tag, input logic [AW-1:0] base);
      chk({tag, "_eject_cnt"}, 32'(ej_cnt), 1);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
      chk({tag, "_nwrites"}, 32'(wa.size()), NP);
      for (int i = 0; i < NP && i < wa.size(); i++) begin
         chk({tag, "_addr"}, 32'(wa[i]), 32'(AW'(base + AW'(NP - 1 - i))));
         chk({tag, "_data"}, 32'(wd[i]), 32'(exp_word(pe_psum[NP-1-i])));
      end
      chk({tag, "_idle_busy"}, 32'(busy), 0);
   endtask

   initial begin
      clr();
      pe_psum[0] = 16'h0011; pe_psum[1] = 16'h0022; pe_psum[2] = 16'h0033; pe_psum[3] = 16'h0044;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_eject", 32'(eject_ctrl), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_wr_valid", 32'(wr_valid), 0);
      chk("reset_wr_addr", 32'(wr_addr), 0);
      chk("reset_wr_data", 32'(wr_data), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic drain with wr_ready held high
      run_drain(10'h100, 0, 1'b0, -1, -1);
      check_drain("basic", 10'h100);
      chk("basic_eject_cyc", 32'(ej_cyc), 1);
      chk("basic_first_valid", 32'(first_v), 3);
      chk("basic_done_cyc", 32'(done_cyc), 7);

      // Backpressure until cycle 12: accepts in 12..15, done in 16
      run_drain(10'h100, 12, 1'b0, -1, -1);
      check_drain("bp", 10'h100);
      chk("bp_done_cyc", 32'(done_cyc), 16);

      // Start re-pulsed while busy is dropped
      run_drain(10'h100, 0, 1'b0, 3, -1);
      check_drain("rebusy", 10'h100);
      chk("rebusy_done_cyc", 32'(done_cyc), 7);

      // Reset mid-drain aborts without done, then a fresh drain completes
      run_drain(10'h100, 99, 1'b0, -1, 4);
      chk("abort_done_cnt", 32'(done_cnt), 0);
      chk("abort_nwrites", 32'(wa.size()), 0);
      run_drain(10'h080, 0, 1'b0, -1, -1);
      check_drain("after_rst", 10'h080);

      // Wrap-around and negative / max positive words
      pe_psum[0] = 16'h8005; pe_psum[1] = 16'h7FFF; pe_psum[2] = 16'h1234; pe_psum[3] = 16'hFFFF;
      run_drain(10'h3FE, 0, 1'b0, -1, -1);
      check_drain("wrap", 10'h3FE);
      chk("wrap_first_addr", 32'(wa.size() > 0 ? wa[0] : 10'h2AA), 32'h001);
      chk("wrap_last_data", 32'(wd.size() > 3 ? wd[3] : 16'hDEAD), exp_word(16'h8005));

      // Random backpressure and bases
      for (int d = 0; d < 20; d++) begin
         logic [AW-1:0] b;
         b = AW'($urandom);
         for (int i = 0; i < NP; i++) pe_psum[i] = DW'($urandom);
         run_drain(b, 0, 1'b1, -1, -1);
         check_drain("rand", b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
